// File: rtl/gpio_filt_pkg.sv
// gpio_filt_pkg: shared defaults and per-bit filter state for gpio_in_filter.
// Edge outputs are built only when GPIO_FILT_EDGE_EN is defined.
package gpio_filt_pkg;

    localparam int GPIO_WIDTH = 32;
    localparam int GPIO_CNT_W = 8;

    // IDLE: synchronised level agrees with the accepted level.
    // COUNT: they disagree and the stable-time is being measured.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } filt_state_e;

endpackage

// File: rtl/gpio_filt_bit.sv
// gpio_filt_bit: one pad bit -- 2-flop synchroniser, debounce counter,
// accepted level, and (with GPIO_FILT_EDGE_EN) rise/fall pulses.
module gpio_filt_bit
    import gpio_filt_pkg::*;
#(
    parameter int CNT_W = GPIO_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pad,
    input  logic             filt_en,
    input  logic [CNT_W-1:0] debounce_len,
    output logic             level,
    output logic             rise,
    output logic             fall
);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_m1;
    filt_state_e      state;

    // A length of 0 is treated as 1, so the threshold never underflows.
    assign len_m1 = (debounce_len == '0) ? '0
                                         : debounce_len - CNT_W'(1);

    assign state = (s2 == stable) ? IDLE : COUNT;

    // Bring the asynchronous pad level into the clock domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pad;
            s2 <= s1;
        end
    end

    // Accept a new level once it has persisted for the stable-time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (!filt_en) begin
            cnt    <= '0;
            stable <= s2;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                end
                COUNT: begin
                    if (cnt >= len_m1) begin
                        stable <= s2;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign level = stable;

`ifdef GPIO_FILT_EDGE_EN
    logic stable_q;

    // Remember the previous accepted level for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
        end else begin
            stable_q <= stable;
        end
    end

    assign rise = stable & ~stable_q;
    assign fall = ~stable & stable_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-bit synchronise + debounce of pad inputs for GPIO_I.
// Define GPIO_FILT_EDGE_EN to build the rise_o/fall_o edge pulses.
module gpio_in_filter
    import gpio_filt_pkg::*;
#(
    parameter int WIDTH = GPIO_WIDTH,
    parameter int CNT_W = GPIO_CNT_W
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [WIDTH-1:0] pad_i,
    input  logic [WIDTH-1:0] filt_en,
    input  logic [CNT_W-1:0] debounce_len,
    output logic [WIDTH-1:0] gpio_i_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    // Bits are independent; only the stable-time is shared.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_filt_bit #(
            .CNT_W(CNT_W)
        ) u_bit (
            .clk         (PCLK),
            .rst_n       (PRESETn),
            .pad         (pad_i[i]),
            .filt_en     (filt_en[i]),
            .debounce_len(debounce_len),
            .level       (gpio_i_o[i]),
            .rise        (rise_o[i]),
            .fall        (fall_o[i])
        );
    end

endmodule
